// File: rtl/count_pkg.sv
// Definitions shared by the counter stream producer and the checker.
package count_pkg;

    localparam int unsigned DEFAULT_WIDTH = 8;

    typedef enum logic [1:0] {
        StHunt,
        StAcquire,
        StLocked
    } state_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating event counter; a clear coincident with an increment leaves one event counted.
module sat_counter #(
    parameter int unsigned ERR_WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 inc,
    input  logic                 clr,
    output logic [ERR_WIDTH-1:0] count
);

    localparam logic [ERR_WIDTH-1:0] Max = '1;
    localparam logic [ERR_WIDTH-1:0] One = ERR_WIDTH'(1);

    always_ff @(posedge clk) begin
        if (rst) begin
            count <= '0;
        end else if (clr) begin
            count <= inc ? One : '0;
        end else if (inc && (count != Max)) begin
            count <= count + One;
        end
    end

endmodule

// File: rtl/count_stream_checker.sv
// Locks onto a +1/-1 stepping count stream and reports continuity breaks while locked.
module count_stream_checker
    import count_pkg::*;
#(
    parameter int unsigned WIDTH      = DEFAULT_WIDTH,
    parameter int unsigned LOCK_COUNT = 4,
    parameter int unsigned ERR_WIDTH  = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 ena,
    input  logic                 sample_valid,
    input  logic [WIDTH-1:0]     sample,
    input  logic                 dir_down,
    input  logic                 err_clear,
    output logic                 locked,
    output logic                 mismatch,
    output logic [ERR_WIDTH-1:0] err_count,
    output logic [WIDTH-1:0]     expected
);

    localparam logic [WIDTH-1:0] One        = WIDTH'(1);
    localparam logic [3:0]       LockTarget = 4'(LOCK_COUNT);

    state_t           state;
    logic [3:0]       match_cnt;
    logic [WIDTH-1:0] nxt;
    logic             accepted;
    logic             hit;
    logic             err_inc;

    assign accepted = ena && sample_valid;
    assign hit      = (sample == expected);
    assign nxt      = dir_down ? (sample - One) : (sample + One);
    assign err_inc  = accepted && (state == StLocked) && !hit;

    always_ff @(posedge clk) begin
        if (rst) begin
            state     <= StHunt;
            match_cnt <= '0;
            expected  <= '0;
            locked    <= 1'b0;
            mismatch  <= 1'b0;
        end else begin
            mismatch <= 1'b0;
            if (accepted) begin
                // Every accepted sample seeds the next expected value, hit or not.
                expected <= nxt;
                unique case (state)
                    StHunt: begin
                        match_cnt <= 4'd1;
                        state     <= StAcquire;
                        locked    <= 1'b0;
                    end
                    StAcquire: begin
                        if (hit) begin
                            match_cnt <= match_cnt + 4'd1;
                            if ((match_cnt + 4'd1) == LockTarget) begin
                                state  <= StLocked;
                                locked <= 1'b1;
                            end
                        end else begin
                            match_cnt <= 4'd1;
                        end
                    end
                    StLocked: begin
                        if (!hit) begin
                            mismatch  <= 1'b1;
                            match_cnt <= 4'd1;
                            state     <= StAcquire;
                            locked    <= 1'b0;
                        end
                    end
                    default: begin
                        state  <= StHunt;
                        locked <= 1'b0;
                    end
                endcase
            end
        end
    end

    sat_counter #(
        .ERR_WIDTH(ERR_WIDTH)
    ) u_err_counter (
        .clk  (clk),
        .rst  (rst),
        .inc  (err_inc),
        .clr  (err_clear),
        .count(err_count)
    );

endmodule

// File: tb/tb_count_stream_checker.sv
// Randomized and directed checks of count_stream_checker against a run-length reference model.
module tb_count_stream_checker;

    localparam int LOCK = 4;

    logic       clk;
    logic       rst;
    logic       ena;
    logic       sample_valid;
    logic [7:0] sample;
    logic       dir_down;
    logic       err_clear;
    logic       locked;
    logic       mismatch;
    logic [7:0] err_count;
    logic [7:0] expected;

    int checks = 0;
    int failures = 0;

    // Reference model: length of the current consistent run, last predicted value.
    bit m_hunt = 1;
    int m_run = 0;
    int m_exp = 0;
    bit m_locked = 0;
    bit m_mis = 0;
    int m_err = 0;

    count_stream_checker #(
        .WIDTH(8),
        .LOCK_COUNT(LOCK),
        .ERR_WIDTH(8)
    ) dut (
        .clk         (clk),
        .rst         (rst),
        .ena         (ena),
        .sample_valid(sample_valid),
        .sample      (sample),
        .dir_down    (dir_down),
        .err_clear   (err_clear),
        .locked      (locked),
        .mismatch    (mismatch),
        .err_count   (err_count),
        .expected    (expected)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    // Drive one cycle, then advance the model and leave outputs ready for sampling.
    task automatic step(input bit v, input bit e, input int s, input bit d, input bit c,
                        input bit r);
        bit acc;
        sample_valid = v;
        ena          = e;
        sample       = s[7:0];
        dir_down     = d;
        err_clear    = c;
        rst          = r;
        @(posedge clk);
        #1;
        if (r) begin
            m_hunt = 1; m_run = 0; m_exp = 0; m_locked = 0; m_mis = 0; m_err = 0;
        end else begin
            acc   = e && v;
            m_mis = 0;
            if (acc) begin
                if (m_hunt) begin
                    m_hunt = 0;
                    m_run  = 1;
                end else if (s == m_exp) begin
                    if (m_run < LOCK) m_run = m_run + 1;
                end else begin
                    if (m_locked) m_mis = 1;
                    m_run = 1;
                end
                m_exp    = d ? (s + 255) % 256 : (s + 1) % 256;
                m_locked = (m_run >= LOCK);
            end
            if (c) m_err = m_mis ? 1 : 0;
            else if (m_mis && m_err < 255) m_err = m_err + 1;
        end
        sample_valid = 1'b0;
        err_clear    = 1'b0;
        rst          = 1'b0;
        ena          = 1'b1;
    endtask

    task automatic test_reset();
        step(1, 1, 5, 0, 0, 1);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL reset_locked got=%b want=0", locked); end
        checks++; if (mismatch !== 1'b0) begin failures++; $display("FAIL reset_mismatch got=%b want=0", mismatch); end
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL reset_err got=%0d want=0", err_count); end
        checks++; if (expected !== 8'd0) begin failures++; $display("FAIL reset_expected got=%0d want=0", expected); end
    endtask

    task automatic test_lock();
        step(1, 1, 0, 0, 0, 1);
        for (int i = 10; i <= 12; i++) begin
            step(1, 1, i, 0, 0, 0);
            checks++; if (locked !== 1'b0 || mismatch !== 1'b0) begin failures++; $display("FAIL lock_early s=%0d locked=%b mismatch=%b want 0/0", i, locked, mismatch); end
        end
        step(1, 1, 13, 0, 0, 0);
        checks++; if (locked !== 1'b1) begin failures++; $display("FAIL lock_locked got=%b want=1", locked); end
        checks++; if (expected !== 8'd14) begin failures++; $display("FAIL lock_expected got=%0d want=14", expected); end
        checks++; if (err_count !== 8'd0 || mismatch !== 1'b0) begin failures++; $display("FAIL lock_err err=%0d mismatch=%b want 0/0", err_count, mismatch); end
    endtask

    task automatic test_wrap();
        int up_seq[4] = '{253, 254, 255, 0};
        int dn_seq[4] = '{1, 0, 255, 254};
        step(1, 1, 0, 0, 0, 1);
        foreach (up_seq[i]) step(1, 1, up_seq[i], 0, 0, 0);
        checks++; if (locked !== 1'b1 || mismatch !== 1'b0) begin failures++; $display("FAIL wrap_up_lock locked=%b mismatch=%b want 1/0", locked, mismatch); end
        step(1, 1, 1, 0, 0, 0);
        checks++; if (expected !== 8'd2 || locked !== 1'b1 || mismatch !== 1'b0) begin failures++; $display("FAIL wrap_up_exp expected=%0d locked=%b want 2/1", expected, locked); end
        step(1, 1, 0, 0, 0, 1);
        foreach (dn_seq[i]) step(1, 1, dn_seq[i], 1, 0, 0);
        checks++; if (locked !== 1'b1 || expected !== 8'd253 || mismatch !== 1'b0) begin failures++; $display("FAIL wrap_down locked=%b expected=%0d want 1/253", locked, expected); end
    endtask

    task automatic test_break();
        step(1, 1, 0, 0, 0, 1);
        for (int i = 17; i <= 20; i++) step(1, 1, i, 0, 0, 0);
        checks++; if (locked !== 1'b1 || expected !== 8'd21) begin failures++; $display("FAIL break_pre locked=%b expected=%0d want 1/21", locked, expected); end
        step(1, 1, 20, 0, 0, 0);
        checks++; if (mismatch !== 1'b1 || locked !== 1'b0) begin failures++; $display("FAIL break_pulse mismatch=%b locked=%b want 1/0", mismatch, locked); end
        checks++; if (err_count !== 8'd1 || expected !== 8'd21) begin failures++; $display("FAIL break_err err=%0d expected=%0d want 1/21", err_count, expected); end
        step(1, 1, 22, 0, 0, 0);
        checks++; if (mismatch !== 1'b0 || expected !== 8'd23 || err_count !== 8'd1) begin failures++; $display("FAIL break_reseed mismatch=%b expected=%0d err=%0d want 0/23/1", mismatch, expected, err_count); end
    endtask

    task automatic test_gating();
        step(1, 1, 0, 0, 0, 1);
        for (int i = 30; i <= 33; i++) step(1, 1, i, 0, 0, 0);
        for (int k = 0; k < 5; k++) begin
            step(1, 0, 99, 0, 0, 0);
            checks++; if (expected !== 8'd34 || locked !== 1'b1 || mismatch !== 1'b0) begin failures++; $display("FAIL gate_ena k=%0d expected=%0d locked=%b mismatch=%b want 34/1/0", k, expected, locked, mismatch); end
        end
        for (int k = 0; k < 3; k++) begin
            step(0, 1, 99, 0, 0, 0);
            checks++; if (expected !== 8'd34 || locked !== 1'b1 || mismatch !== 1'b0) begin failures++; $display("FAIL gate_valid k=%0d expected=%0d locked=%b want 34/1", k, expected, locked); end
        end
        step(1, 1, 34, 0, 0, 0);
        checks++; if (expected !== 8'd35 || locked !== 1'b1 || err_count !== 8'd0) begin failures++; $display("FAIL gate_resume expected=%0d locked=%b err=%0d want 35/1/0", expected, locked, err_count); end
    endtask

    task automatic test_saturation();
        int e;
        int b;
        step(1, 1, 0, 0, 0, 1);
        for (int i = 0; i <= 3; i++) step(1, 1, i, 0, 0, 0);
        e = 4;
        for (int n = 0; n < 260; n++) begin
            b = (e + 5) % 256;
            step(1, 1, b, 0, 0, 0);
            for (int j = 1; j <= 3; j++) step(1, 1, (b + j) % 256, 0, 0, 0);
            e = (b + 4) % 256;
        end
        checks++; if (err_count !== 8'd255 || locked !== 1'b1) begin failures++; $display("FAIL sat_stick err=%0d locked=%b want 255/1", err_count, locked); end
        step(1, 1, (e + 5) % 256, 0, 1, 0);
        checks++; if (err_count !== 8'd1 || mismatch !== 1'b1) begin failures++; $display("FAIL sat_clear_break err=%0d mismatch=%b want 1/1", err_count, mismatch); end
        step(0, 0, 0, 0, 1, 0);
        checks++; if (err_count !== 8'd0) begin failures++; $display("FAIL sat_clear_alone err=%0d want 0", err_count); end
    endtask

    task automatic test_reset_mid_lock();
        int b;
        step(1, 1, 0, 0, 0, 1);
        for (int i = 40; i <= 43; i++) step(1, 1, i, 0, 0, 0);
        b = 100;
        for (int n = 0; n < 3; n++) begin
            for (int j = 0; j < 4; j++) step(1, 1, b + j, 0, 0, 0);
            b = b + 20;
        end
        checks++; if (err_count !== 8'd3 || locked !== 1'b1) begin failures++; $display("FAIL rml_pre err=%0d locked=%b want 3/1", err_count, locked); end
        step(1, 1, 77, 0, 0, 1);
        checks++; if (locked !== 1'b0 || err_count !== 8'd0 || expected !== 8'd0 || mismatch !== 1'b0) begin failures++; $display("FAIL rml_reset locked=%b err=%0d expected=%0d want 0/0/0", locked, err_count, expected); end
        for (int i = 50; i <= 52; i++) step(1, 1, i, 0, 0, 0);
        checks++; if (locked !== 1'b0) begin failures++; $display("FAIL rml_early locked=%b want 0", locked); end
        step(1, 1, 53, 0, 0, 0);
        checks++; if (locked !== 1'b1 || expected !== 8'd54) begin failures++; $display("FAIL rml_relock locked=%b expected=%0d want 1/54", locked, expected); end
    endtask

    task automatic test_random();
        bit v, e, d, c, r;
        int s;
        d = 0;
        step(1, 1, 0, 0, 0, 1);
        for (int n = 0; n < 3000; n++) begin
            v = ($urandom_range(0, 9) < 8);
            e = ($urandom_range(0, 9) < 9);
            c = ($urandom_range(0, 49) == 0);
            r = ($urandom_range(0, 499) == 0);
            if ($urandom_range(0, 99) == 0) d = ~d;
            s = ($urandom_range(0, 9) < 9) ? m_exp : $urandom_range(0, 255);
            step(v, e, s, d, c, r);
            checks++; if (locked !== m_locked) begin failures++; $display("FAIL rnd_locked n=%0d got=%b want=%b", n, locked, m_locked); end
            checks++; if (mismatch !== m_mis) begin failures++; $display("FAIL rnd_mismatch n=%0d got=%b want=%b", n, mismatch, m_mis); end
            checks++; if (err_count !== m_err[7:0]) begin failures++; $display("FAIL rnd_err n=%0d got=%0d want=%0d", n, err_count, m_err); end
            checks++; if (expected !== m_exp[7:0]) begin failures++; $display("FAIL rnd_expected n=%0d got=%0d want=%0d", n, expected, m_exp); end
        end
    endtask

    initial begin
        rst = 1'b1; ena = 1'b0; sample_valid = 1'b0; sample = '0;
        dir_down = 1'b0; err_clear = 1'b0;
        test_reset();
        test_lock();
        test_wrap();
        test_break();
        test_gating();
        test_saturation();
        test_reset_mid_lock();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
